mem_access: RTL and testbench

// MEM-stage data-memory initiator. Takes the load/store request computed in EX (op, effective address,

---
 rtl/mem_access.sv | 191 +++++++++++++++++++
 tb/tb_mem_access.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data-memory initiator: runs one req/ack bus transaction per
// load/store, stalls upstream while busy, and registers a writeback record.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_*_i             request from EX (valid, op, addr, wdata, wreg_*)
//   bus_*_o / bus_*_i   data-RAM bus (req held until ack, big-endian lanes)
//   wb_wreg_*_o         registered writeback record to WB
//   stallreq_from_mem   combinational freeze of upstream stages
//   misalign_o          1-cycle pulse, misaligned LW/SW dropped
//   bus_err_o           1-cycle pulse, bus timeout abort
module mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [2:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        mem_wreg_en_i,
   input  logic [4:0]  mem_wreg_addr_i,
   input  logic [31:0] mem_wreg_data_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        wb_wreg_en_o,
   output logic [4:0]  wb_wreg_addr_o,
   output logic [31:0] wb_wreg_data_o,
   output logic        stallreq_from_mem,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int CW = $clog2(TIMEOUT);

   localparam logic [2:0] OP_LB = 3'd1;
   localparam logic [2:0] OP_LW = 3'd2;
   localparam logic [2:0] OP_SB = 3'd3;
   localparam logic [2:0] OP_SW = 3'd4;

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t state_q, state_d;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_lb_q, is_lb_d;
   logic [1:0]    lane_q, lane_d;
   logic          wen_q, wen_d;
   logic [4:0]    wra_q, wra_d;

   logic        req_d, we_d;
   logic [31:0] addr_d, wdata_d;
   logic [3:0]  be_d;
   logic        wb_en_d, mis_d, err_d;
   logic [4:0]  wb_addr_d;
   logic [31:0] wb_data_d;

   logic is_lb, is_sb, is_word, is_mem, accept;
   logic [7:0]  rbyte;
   logic [31:0] ldata;

   assign is_lb   = (mem_op_i == OP_LB);
   assign is_sb   = (mem_op_i == OP_SB);
   assign is_word = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
   assign is_mem  = is_lb || is_sb || is_word;
   // word accesses need addr[1:0]==0; byte accesses are always aligned
   assign accept  = mem_valid_i && is_mem &&
                    (!is_word || (mem_addr_i[1:0] == 2'b00));

   assign stallreq_from_mem = ((state_q == IDLE) && accept) ||
                              (state_q == BUS);

   // lane 0 is the most significant byte
   always_comb begin
      rbyte = bus_rdata_i[31:24];
      unique case (lane_q)
         2'd0: rbyte = bus_rdata_i[31:24];
         2'd1: rbyte = bus_rdata_i[23:16];
         2'd2: rbyte = bus_rdata_i[15:8];
         2'd3: rbyte = bus_rdata_i[7:0];
      endcase
   end

   assign ldata = is_lb_q ? {{24{rbyte[7]}}, rbyte} : bus_rdata_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_lb_d   = is_lb_q;
      lane_d    = lane_q;
      wen_d     = wen_q;
      wra_d     = wra_q;
      req_d     = bus_req_o;
      we_d      = bus_we_o;
      addr_d    = bus_addr_o;
      be_d      = bus_be_o;
      wdata_d   = bus_wdata_o;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_wreg_addr_o;
      wb_data_d = wb_wreg_data_o;
      mis_d     = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         // DONE lasts one cycle and takes new work exactly like IDLE
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               state_d = BUS;
               cnt_d   = '0;
               is_lb_d = is_lb;
               lane_d  = mem_addr_i[1:0];
               wen_d   = mem_wreg_en_i;
               wra_d   = mem_wreg_addr_i;
               req_d   = 1'b1;
               we_d    = is_sb || (mem_op_i == OP_SW);
               addr_d  = {mem_addr_i[31:2], 2'b00};
               be_d    = is_word ? 4'b1111
                                 : (4'b1000 >> mem_addr_i[1:0]);
               wdata_d = is_sb ? {4{mem_wdata_i[7:0]}}
                               : mem_wdata_i;
            end else if (mem_valid_i && is_mem) begin
               mis_d = 1'b1;
            end else if (mem_valid_i) begin
               wb_en_d   = mem_wreg_en_i;
               wb_addr_d = mem_wreg_addr_i;
               wb_data_d = mem_wreg_data_i;
            end
         end
         BUS: begin
            if (bus_ack_i) begin
               state_d   = DONE;
               req_d     = 1'b0;
               wb_en_d   = wen_q && !bus_we_o;
               wb_addr_d = wra_q;
               wb_data_d = ldata;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         is_lb_q        <= 1'b0;
         lane_q         <= 2'd0;
         wen_q          <= 1'b0;
         wra_q          <= 5'd0;
         bus_req_o      <= 1'b0;
         bus_we_o       <= 1'b0;
         bus_addr_o     <= 32'd0;
         bus_be_o       <= 4'd0;
         bus_wdata_o    <= 32'd0;
         wb_wreg_en_o   <= 1'b0;
         wb_wreg_addr_o <= 5'd0;
         wb_wreg_data_o <= 32'd0;
         misalign_o     <= 1'b0;
         bus_err_o      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         is_lb_q        <= is_lb_d;
         lane_q         <= lane_d;
         wen_q          <= wen_d;
         wra_q          <= wra_d;
         bus_req_o      <= req_d;
         bus_we_o       <= we_d;
         bus_addr_o     <= addr_d;
         bus_be_o       <= be_d;
         bus_wdata_o    <= wdata_d;
         wb_wreg_en_o   <= wb_en_d;
         wb_wreg_addr_o <= wb_addr_d;
         wb_wreg_data_o <= wb_data_d;
         misalign_o     <= mis_d;
         bus_err_o      <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalign, timeout,
// reset mid-transaction and acceptance while in DONE.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic [2:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        mem_wreg_en_i;
   logic [4:0]  mem_wreg_addr_i;
   logic [31:0] mem_wreg_data_i;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        wb_wreg_en_o;
   logic [4:0]  wb_wreg_addr_o;
   logic [31:0] wb_wreg_data_o;
   logic        stallreq_from_mem;
   logic        misalign_o;
   logic        bus_err_o;

   int total = 0;
   int bad = 0;

   mem_access #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_op_i(mem_op_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_wreg_en_i(mem_wreg_en_i),
      .mem_wreg_addr_i(mem_wreg_addr_i),
      .mem_wreg_data_i(mem_wreg_data_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
      .bus_ack_i(bus_ack_i),
      .wb_wreg_en_o(wb_wreg_en_o),
      .wb_wreg_addr_o(wb_wreg_addr_o),
      .wb_wreg_data_o(wb_wreg_data_o),
      .stallreq_from_mem(stallreq_from_mem),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wdat);
      mem_valid_i     = v;
      mem_op_i        = op;
      mem_addr_i      = a;
      mem_wdata_i     = wd;
      mem_wreg_en_i   = we;
      mem_wreg_addr_i = wa;
      mem_wreg_data_i = wdat;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_ack_i = 1'b0;
      bus_rdata_i = 32'd0;
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      tick();
      total++;
      if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0) begin
         bad++;
         $display("FAIL rst_req got=%b%b exp=00", bus_req_o, bus_we_o);
      end
      total++;
      if (bus_addr_o !== 32'd0 || bus_be_o !== 4'd0 ||
          bus_wdata_o !== 32'd0) begin
         bad++;
         $display("FAIL rst_bus got=%h %h %h exp=0",
                  bus_addr_o, bus_be_o, bus_wdata_o);
      end
      total++;
      if (wb_wreg_en_o !== 1'b0 || wb_wreg_addr_o !== 5'd0 ||
          wb_wreg_data_o !== 32'd0) begin
         bad++;
         $display("FAIL rst_wb got=%b %h %h exp=0", wb_wreg_en_o,
                  wb_wreg_addr_o, wb_wreg_data_o);
      end
      total++;
      if (misalign_o !== 1'b0 || bus_err_o !== 1'b0 ||
          stallreq_from_mem !== 1'b0) begin
         bad++;
         $display("FAIL rst_flags got=%b%b%b exp=000", misalign_o,
                  bus_err_o, stallreq_from_mem);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lw();
      int stalls = 0;
      drive(1'b1, 3'd2, 32'h100, 32'd0, 1'b1, 5'd8, 32'd0);
      #1;
      if (stallreq_from_mem === 1'b1) stalls++;
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      if (stallreq_from_mem === 1'b1) stalls++;
      total++;
      if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0) begin
         bad++;
         $display("FAIL lw_req got=%b%b exp=10", bus_req_o, bus_we_o);
      end
      total++;
      if (bus_addr_o !== 32'h100 || bus_be_o !== 4'b1111) begin
         bad++;
         $display("FAIL lw_bus got=%h %b exp=00000100 1111",
                  bus_addr_o, bus_be_o);
      end
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'hDEADBEEF;
      tick();
      bus_ack_i = 1'b0;
      bus_rdata_i = 32'd0;
      #1;
      if (stallreq_from_mem === 1'b1) stalls++;
      total++;
      if (bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL lw_req_drop got=%b exp=0", bus_req_o);
      end
      total++;
      if (wb_wreg_en_o !== 1'b1 || wb_wreg_addr_o !== 5'd8 ||
          wb_wreg_data_o !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL lw_wb got=%b %0d %h exp=1 8 deadbeef",
                  wb_wreg_en_o, wb_wreg_addr_o, wb_wreg_data_o);
      end
      tick();
      total++;
      if (wb_wreg_en_o !== 1'b0) begin
         bad++;
         $display("FAIL lw_wb_end got=%b exp=0", wb_wreg_en_o);
      end
      total++;
      if (stalls != 2) begin
         bad++;
         $display("FAIL lw_stall_cycles got=%0d exp=2", stalls);
      end
   endtask

   task automatic test_lb();
      logic [31:0] av [4] = '{32'h203, 32'h200, 32'h201, 32'h202};
      logic [31:0] rv [4] = '{32'h000000F0, 32'h7F000000,
                              32'h00AB0000, 32'h00001200};
      logic [3:0]  bv [4] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
      logic [31:0] dv [4] = '{32'hFFFFFFF0, 32'h0000007F,
                              32'hFFFFFFAB, 32'h00000012};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'd1, av[i], 32'd0, 1'b1, 5'd5, 32'd0);
         tick();
         drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         total++;
         if (bus_req_o !== 1'b1 || bus_be_o !== bv[i] ||
             bus_addr_o !== {av[i][31:2], 2'b00}) begin
            bad++;
            $display("FAIL lb_bus%0d got=%b %b %h exp=1 %b", i,
                     bus_req_o, bus_be_o, bus_addr_o, bv[i]);
         end
         bus_ack_i = 1'b1;
         bus_rdata_i = rv[i];
         tick();
         bus_ack_i = 1'b0;
         total++;
         if (wb_wreg_en_o !== 1'b1 || wb_wreg_data_o !== dv[i]) begin
            bad++;
            $display("FAIL lb_wb%0d got=%b %h exp=1 %h", i,
                     wb_wreg_en_o, wb_wreg_data_o, dv[i]);
         end
         tick();
      end
   endtask

   task automatic test_store();
      drive(1'b1, 3'd3, 32'h11, 32'h12345678, 1'b1, 5'd3, 32'd0);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 ||
          bus_addr_o !== 32'h10 || bus_be_o !== 4'b0100 ||
          bus_wdata_o !== 32'h78787878) begin
         bad++;
         $display("FAIL sb_bus got=%b%b %h %b %h exp=11 10 0100 78787878",
                  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o);
      end
      tick();
      tick();
      total++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h10 ||
          bus_wdata_o !== 32'h78787878 || bus_we_o !== 1'b1) begin
         bad++;
         $display("FAIL sb_hold got=%b %h %h exp=1 10 78787878",
                  bus_req_o, bus_addr_o, bus_wdata_o);
      end
      bus_ack_i = 1'b1;
      tick();
      bus_ack_i = 1'b0;
      total++;
      if (bus_req_o !== 1'b0 || wb_wreg_en_o !== 1'b0) begin
         bad++;
         $display("FAIL sb_done got=%b %b exp=0 0",
                  bus_req_o, wb_wreg_en_o);
      end
      tick();
      drive(1'b1, 3'd4, 32'h24, 32'hA5A5_1234, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus_we_o !== 1'b1 || bus_be_o !== 4'b1111 ||
          bus_addr_o !== 32'h24 || bus_wdata_o !== 32'hA5A51234) begin
         bad++;
         $display("FAIL sw_bus got=%b %b %h %h exp=1 1111 24 a5a51234",
                  bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o);
      end
      bus_ack_i = 1'b1;
      tick();
      bus_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_misalign();
      drive(1'b1, 3'd2, 32'h102, 32'd0, 1'b1, 5'd4, 32'd0);
      #1;
      total++;
      if (stallreq_from_mem !== 1'b0) begin
         bad++;
         $display("FAIL mis_stall got=%b exp=0", stallreq_from_mem);
      end
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if (misalign_o !== 1'b1 || bus_req_o !== 1'b0 ||
          wb_wreg_en_o !== 1'b0) begin
         bad++;
         $display("FAIL mis_pulse got=%b %b %b exp=1 0 0",
                  misalign_o, bus_req_o, wb_wreg_en_o);
      end
      tick();
      total++;
      if (misalign_o !== 1'b0 || bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL mis_end got=%b %b exp=0 0",
                  misalign_o, bus_req_o);
      end
   endtask

   task automatic test_timeout();
      drive(1'b1, 3'd2, 32'h300, 32'd0, 1'b1, 5'd6, 32'd0);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 1; i < 16; i++) begin
         tick();
         total++;
         if (bus_req_o !== 1'b1 || bus_err_o !== 1'b0) begin
            bad++;
            $display("FAIL to_wait%0d got=%b %b exp=1 0", i,
                     bus_req_o, bus_err_o);
         end
      end
      tick();
      total++;
      if (bus_req_o !== 1'b0 || bus_err_o !== 1'b1 ||
          wb_wreg_en_o !== 1'b0 || stallreq_from_mem !== 1'b0) begin
         bad++;
         $display("FAIL to_abort got=%b %b %b %b exp=0 1 0 0",
                  bus_req_o, bus_err_o, wb_wreg_en_o, stallreq_from_mem);
      end
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'h1111_2222;
      tick();
      bus_ack_i = 1'b0;
      total++;
      if (bus_err_o !== 1'b0 || wb_wreg_en_o !== 1'b0 ||
          bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL to_stray got=%b %b %b exp=0 0 0",
                  bus_err_o, wb_wreg_en_o, bus_req_o);
      end
      tick();
      total++;
      if (wb_wreg_en_o !== 1'b0 || stallreq_from_mem !== 1'b0) begin
         bad++;
         $display("FAIL to_idle got=%b %b exp=0 0",
                  wb_wreg_en_o, stallreq_from_mem);
      end
   endtask

   task automatic test_rst_bus();
      drive(1'b1, 3'd2, 32'h400, 32'd0, 1'b1, 5'd7, 32'd0);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus_req_o !== 1'b1) begin
         bad++;
         $display("FAIL rb_req got=%b exp=1", bus_req_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (bus_req_o !== 1'b0 || stallreq_from_mem !== 1'b0) begin
         bad++;
         $display("FAIL rb_drop got=%b %b exp=0 0",
                  bus_req_o, stallreq_from_mem);
      end
      drive(1'b1, 3'd0, 32'h0, 32'd0, 1'b1, 5'd3, 32'hCAFEF00D);
      tick();
      total++;
      if (wb_wreg_en_o !== 1'b1 || wb_wreg_addr_o !== 5'd3 ||
          wb_wreg_data_o !== 32'hCAFEF00D || bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL rb_pass got=%b %0d %h exp=1 3 cafef00d",
                  wb_wreg_en_o, wb_wreg_addr_o, wb_wreg_data_o);
      end
      drive(1'b1, 3'd7, 32'h0, 32'd0, 1'b1, 5'd12, 32'h0BAD_F00D);
      tick();
      total++;
      if (wb_wreg_en_o !== 1'b1 || wb_wreg_data_o !== 32'h0BADF00D ||
          bus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL rb_op7 got=%b %h %b exp=1 0badf00d 0",
                  wb_wreg_en_o, wb_wreg_data_o, bus_req_o);
      end
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 5'd3, 32'd0);
      tick();
      total++;
      if (wb_wreg_en_o !== 1'b0) begin
         bad++;
         $display("FAIL rb_novalid got=%b exp=0", wb_wreg_en_o);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 3'd2, 32'h40, 32'd0, 1'b1, 5'd2, 32'd0);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'h0000_00AA;
      tick();
      bus_ack_i = 1'b0;
      drive(1'b1, 3'd1, 32'h81, 32'd0, 1'b1, 5'd9, 32'd0);
      #1;
      total++;
      if (stallreq_from_mem !== 1'b0 || wb_wreg_data_o !== 32'hAA) begin
         bad++;
         $display("FAIL b2b_done got=%b %h exp=0 000000aa",
                  stallreq_from_mem, wb_wreg_data_o);
      end
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h80 ||
          bus_be_o !== 4'b0100 || wb_wreg_en_o !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept got=%b %h %b %b exp=1 80 0100 0",
                  bus_req_o, bus_addr_o, bus_be_o, wb_wreg_en_o);
      end
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'h0080_0000;
      tick();
      bus_ack_i = 1'b0;
      total++;
      if (wb_wreg_en_o !== 1'b1 || wb_wreg_addr_o !== 5'd9 ||
          wb_wreg_data_o !== 32'hFFFFFF80) begin
         bad++;
         $display("FAIL b2b_wb got=%b %0d %h exp=1 9 ffffff80",
                  wb_wreg_en_o, wb_wreg_addr_o, wb_wreg_data_o);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb();
      test_store();
      test_misalign();
      test_timeout();
      test_rst_bus();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
